// File: rtl/diff_modulo_operator_pkg.sv
// usf_pkg: shared FSM states, fold helper and default sizes for the recovery chain
package usf_pkg;
    localparam int default_width = 16;
    localparam int default_order = 2;

    typedef enum logic [1:0] {IDLE, DIFF, FOLD} state_t;

    // Keep the low mod_bits bits and sign-extend them: ((v + lambda) mod 2*lambda) - lambda
    function automatic logic signed [63:0] centered_mod(input logic signed [63:0] value, input int mod_bits);
        return (value <<< (64 - mod_bits)) >>> (64 - mod_bits);
    endfunction
endpackage

// File: rtl/diff_modulo_operator_if.sv
// diff_modulo_operator_if: en-strobed sample in, folded result out
interface diff_modulo_operator_if #(parameter int width = 16);
    logic en;
    logic signed [width-1:0] y;
    logic [width-1:0] out;
    logic valid;
    logic busy;
    logic overrun;

    modport master(output en, y, input out, valid, busy, overrun);
    modport slave(input en, y, output out, valid, busy, overrun);
endinterface

// File: rtl/diff_modulo_operator_fold.sv
// centered_mod_fold: combinational truncate-and-sign-extend fold
module centered_mod_fold
    import usf_pkg::*;
#(
    parameter int in_width = 18,
    parameter int width    = 16,
    parameter int mod_bits = 16
) (
    input  logic signed [in_width-1:0] value,
    output logic [width-1:0]           folded
);
    assign folded = width'(centered_mod(64'(value), mod_bits));
endmodule

// File: rtl/diff_modulo_operator.sv
// diff_modulo_operator: iterative order-N finite difference followed by a centered modulo fold
module diff_modulo_operator
    import usf_pkg::*;
#(
    parameter int order      = default_order,
    parameter int order_bits = 2,
    parameter int width      = default_width,
    parameter int mod_bits   = 16
) (
    input logic clk,
    input logic reset,
    diff_modulo_operator_if.slave bus
);
    localparam int acc_width = width + order;

    state_t state, state_n;
    logic signed [acc_width-1:0] t, prev_k;
    logic signed [acc_width-1:0] prev [order];
    logic [order_bits-1:0] k, fill;
    logic primed;
    logic last;
    logic [width-1:0] folded;

    assign last = k == order_bits'(order - 1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: IDLE waits for en, DIFF runs one order per clock, FOLD lasts one cycle
    always_comb begin
        state_n = (state == IDLE && bus.en) ? DIFF :
                  (state == DIFF && last)   ? FOLD :
                  (state == FOLD)           ? IDLE : state;
    end

    // Select the history entry for the current order, feeding the single shared subtractor
    always_comb begin
        prev_k = '0;
        for (int i = 0; i < order; i++) if (k == order_bits'(i)) prev_k = prev[i];
    end

    centered_mod_fold #(.in_width(acc_width), .width(width), .mod_bits(mod_bits)) u_fold (
        .value (t),
        .folded(folded)
    );

    // Datapath: capture, difference one order per cycle, publish the folded result when primed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t           <= '0;
            k           <= '0;
            fill        <= '0;
            primed      <= 1'b0;
            bus.out     <= '0;
            bus.valid   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.overrun <= 1'b0;
            for (int i = 0; i < order; i++) prev[i] <= '0;
        end else begin
            bus.valid   <= 1'b0;
            bus.overrun <= bus.overrun | (bus.en & (state != IDLE));
            if (state == IDLE && bus.en) begin
                t        <= acc_width'(bus.y);
                k        <= '0;
                bus.busy <= 1'b1;
                primed   <= fill == order_bits'(order);
                fill     <= (fill == order_bits'(order)) ? fill : fill + 1'b1;
            end
            if (state == DIFF) begin
                t <= t - prev_k;
                for (int i = 0; i < order; i++) if (k == order_bits'(i)) prev[i] <= t;
                k <= k + 1'b1;
            end
            if (state == FOLD) begin
                if (primed) begin
                    bus.out   <= folded;
                    bus.valid <= 1'b1;
                end
                bus.busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_diff_modulo_operator.sv
// tb_diff_modulo_operator: directed vectors, expected results queued and checked by a valid monitor
module tb_diff_modulo_operator;
    import usf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r2, r4, r1;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] v;
        int c;
    } exp_t;
    exp_t q2[$], q4[$], q1[$];

    diff_modulo_operator_if #(16) b2();
    diff_modulo_operator_if #(16) b4();
    diff_modulo_operator_if #(16) b1();

    diff_modulo_operator #(.order(2), .order_bits(2), .width(16), .mod_bits(16)) u2 (.clk(clk), .reset(r2), .bus(b2));
    diff_modulo_operator #(.order(2), .order_bits(2), .width(16), .mod_bits(4))  u4 (.clk(clk), .reset(r4), .bus(b4));
    diff_modulo_operator #(.order(1), .order_bits(1), .width(16), .mod_bits(16)) u1 (.clk(clk), .reset(r1), .bus(b1));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Caller sits at a negedge; en is sampled on the following posedge
    task automatic send(input int d, input logic [15:0] yv, input bit ev, input logic [15:0] e, input int gap);
        exp_t x;
        x.v = e;
        x.c = cyc + 1;
        case (d)
            2: begin b2.en = 1'b1; b2.y = yv; if (ev) q2.push_back(x); end
            4: begin b4.en = 1'b1; b4.y = yv; if (ev) q4.push_back(x); end
            default: begin b1.en = 1'b1; b1.y = yv; if (ev) q1.push_back(x); end
        endcase
        @(negedge clk);
        b2.en = 1'b0;
        b4.en = 1'b0;
        b1.en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic mon(input int d, input logic [15:0] o);
        exp_t x;
        bit have;
        have = 1'b0;
        case (d)
            2: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
            4: if (q4.size() > 0) begin x = q4.pop_front(); have = 1'b1; end
            default: if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got out=%h expected no valid", d, o);
        end else begin
            chk($sformatf("out_dut%0d", d), 32'(o), 32'(x.v));
            chk($sformatf("latency_dut%0d", d), 32'(cyc - x.c), (d == 1) ? 32'd2 : 32'd3);
        end
    endtask

    always @(negedge clk) begin
        if (b2.valid) mon(2, b2.out);
        if (b4.valid) mon(4, b4.out);
        if (b1.valid) mon(1, b1.out);
    end

    initial begin
        {b2.en, b4.en, b1.en} = '0;
        b2.y = '0;
        b4.y = '0;
        b1.y = '0;
        {r2, r4, r1} = '0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(b2.out), 0);
        chk("reset_valid", 32'(b2.valid), 0);
        chk("reset_busy", 32'(b2.busy), 0);
        chk("reset_overrun", 32'(b2.overrun), 0);
        {r2, r4, r1} = '1;
        @(negedge clk);
        send(2, 16'd1, 0, 16'h0, 9);
        send(2, 16'd4, 0, 16'h0, 9);
        send(2, 16'd7, 1, 16'h0000, 9);
        send(2, 16'd9, 1, 16'hFFFF, 9);
        send(2, 16'd14, 1, 16'h0003, 9);
        chk("out_held", 32'(b2.out), 32'h3);
        send(4, 16'd0, 0, 16'h0, 9);
        send(4, 16'd0, 0, 16'h0, 9);
        send(4, 16'd10, 1, 16'hFFFA, 9);
        r4 = 1'b0;
        @(negedge clk);
        r4 = 1'b1;
        @(negedge clk);
        send(4, 16'd0, 0, 16'h0, 9);
        send(4, 16'd0, 0, 16'h0, 9);
        send(4, 16'd7, 1, 16'h0007, 9);
        send(1, 16'h7FFF, 0, 16'h0, 9);
        send(1, 16'h8000, 1, 16'h0001, 9);
        r2 = 1'b0;
        @(negedge clk);
        r2 = 1'b1;
        @(negedge clk);
        send(2, 16'd5, 0, 16'h0, 0);
        chk("busy_after_strobe", 32'(b2.busy), 1);
        chk("overrun_before", 32'(b2.overrun), 0);
        send(2, 16'd100, 0, 16'h0, 8);
        chk("overrun_set", 32'(b2.overrun), 1);
        send(2, 16'd5, 0, 16'h0, 9);
        send(2, 16'd5, 1, 16'h0000, 9);
        send(2, 16'd20, 1, 16'h000F, 9);
        chk("overrun_sticky", 32'(b2.overrun), 1);
        send(2, 16'd30, 0, 16'h0, 0);
        #2 r2 = 1'b0;
        #1;
        chk("async_out", 32'(b2.out), 0);
        chk("async_valid", 32'(b2.valid), 0);
        chk("async_busy", 32'(b2.busy), 0);
        chk("async_overrun", 32'(b2.overrun), 0);
        @(negedge clk);
        r2 = 1'b1;
        @(negedge clk);
        send(2, 16'd1, 0, 16'h0, 9);
        send(2, 16'd4, 0, 16'h0, 9);
        send(2, 16'd7, 1, 16'h0000, 9);
        repeat (10) @(negedge clk);
        chk("pending_dut2", 32'(q2.size()), 0);
        chk("pending_dut4", 32'(q4.size()), 0);
        chk("pending_dut1", 32'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/diff_modulo_operator.md
# diff_modulo_operator

Front-end stage of the hardware recovery chain. It computes the ORDER-th finite difference of the modulo-folded input samples and applies the centered modulo fold M_λ. The result feeds antidiff_operator through the same `en`-strobed, one-sample-per-strobe protocol. Differencing is iterative, one order per clock, so a single subtractor is shared across all orders.

## Interface
- `order`, 2: difference order N, ≥1.
- `order_bits`, 2: width of the stage counter; must hold values 0..order.
- `width`, 16: sample width, two's complement.
- `mod_bits`, 16: fold modulus 2λ = 2^mod_bits; 1 ≤ mod_bits ≤ width.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `en` in 1: sample strobe, one cycle wide; `y` is captured on the edge where `en`=1 and the block is idle.
- `y` in width: signed input sample.
- `out` out width: folded N-th difference, sign-extended to width.
- `valid` out 1: one-cycle pulse when `out` updates with a primed result.
- `busy` out 1: high while a sample is being processed.
- `overrun` out 1: sticky; set when `en` arrives while busy; cleared only by reset.

## Operation
- Internal accumulator width is `width+order` bits, signed; no intermediate saturation.
- Storage: `prev[0..order-1]` holds the last value of each difference order. All entries are 0 after reset.
- State machine: IDLE → DIFF → FOLD → IDLE.
- IDLE, on `en`=1:
  - `t <= sext(y)`, `k <= 0`, `busy <= 1`.
  - Go to DIFF.
- DIFF, each cycle:
  - `t <= t − prev[k]` and `prev[k] <= t`.
  - `k <= k+1`.
  - After the update with `k = order−1`, go to FOLD.
- FOLD:
  - Centered modulo: take bits `[mod_bits−1:0]` of `t` and sign-extend to width. This equals ((t+λ) mod 2λ) − λ.
  - If primed: `out <= folded`, `valid <= 1` for this one cycle.
  - If not primed: `out` is held and `valid` stays 0.
  - `busy <= 0`, return to IDLE.
- Priming:
  - `fill` counter counts accepted samples, saturating at `order`.
  - Primed means `fill == order` before the current sample is accepted. The first `order` samples produce no `valid`.
- `en` while busy:
  - The sample is dropped and state is unchanged.
  - `overrun` is set.
- `en` held high across IDLE re-entry is accepted again (level-sampled in IDLE). Upstream must keep `en` one cycle wide.

## Timing
- Reset values: `out`=0, `valid`=0, `busy`=0, `overrun`=0; state IDLE; `k`=0, `fill`=0, `prev[*]`=0.
- Reset is asynchronous. Asserting it mid-DIFF aborts the sample and clears all history; the next sample starts unprimed.
- Let edge E be the one where `en` is sampled.
  - `busy` is high in cycles E+1..E+order+1.
  - `out`/`valid` update at edge E+order+1.
  - Latency is order+1 clocks.
- Minimum strobe spacing is order+2 clocks. `en` on the same edge that FOLD→IDLE occurs counts as busy (overrun).
- `out` is stable between `valid` pulses, which matches antidiff_operator sampling on its next `en`.

## Structure
- Shared package `usf_pkg`:
  - state enum (IDLE, DIFF, FOLD);
  - function `centered_mod(value, mod_bits)`;
  - default width and order constants shared with antidiff_operator.
- One natural sub-module, `centered_mod_fold`: combinational truncate-and-sign-extend, reusable by the residual stage.
- The difference datapath stays in the top module: a `prev` register array, one subtractor, and the counter `k`.

## Test plan
- Basic differencing, order=2, mod_bits=16, one strobe every 10 clocks, `y` = 1,4,7,9,14:
  - exactly 3 `valid` pulses;
  - `out` = 0x0000, 0xFFFF, 0x0003;
  - each pulse 3 clocks after its strobe.
- Fold, order=2, mod_bits=4, `y` = 0,0,10: third result is 0xFFFA (−6). A second run with `y` = 0,0,7 gives 0x0007.
- Overrun: strobe `y`=5, then a second strobe 1 clock later:
  - `overrun`=1 from the next edge;
  - the second sample is ignored and the stage history reflects only 5.
- Reset mid-operation: deassert `reset` during DIFF of the third sample:
  - all outputs 0 immediately, without waiting for a clock edge;
  - the next two samples give no `valid`.
- Order 1 and wide values, order=1, mod_bits=16, `y` = 0x7FFF, 0x8000:
  - second result `t` = −65535; folded `out` = 0x0001;
  - latency is 2 clocks.
- Chained: feed the `out`/`valid` pulses into antidiff_operator (order 2) and confirm it reconstructs the original unfolded input sequence after priming.
